// File: rtl/pulse_capture_pkg.sv
// Shared shape package: default capture dimensions and the window FSM encoding
// used by the pulse generators and the pulse capture block.
package pulse_capture_pkg;

    localparam int DEFAULT_WINDOW_CYCLES = 50_000_000;
    localparam int DEFAULT_CNT_W         = 16;
    localparam int DEFAULT_PER_W         = 24;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } cap_state_t;

    // Width of a counter that must reach cycles-1; never narrower than one bit.
    function automatic int win_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/pulse_capture_chan.sv
// One capture axis: synchroniser, rising-edge detect, per-window edge count and
// last edge-to-edge interval. Presents the closing-window values combinationally.
module pulse_capture_chan
    import pulse_capture_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W,
    parameter int PER_W = DEFAULT_PER_W
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             pulse,
    input  logic             active,
    input  logic             win_last,
    output logic [CNT_W-1:0] count_final,
    output logic [PER_W-1:0] period_final
);

    logic [2:0]       sync_reg;
    logic             edge_det;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [PER_W-1:0] ivl_reg, ivl_next;
    logic [PER_W-1:0] per_reg, per_next;
    logic             seen_reg, seen_next;

    // Two flops for metastability, the third only remembers the previous level.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], pulse};
        end
    end

    assign edge_det = sync_reg[1] & ~sync_reg[2];

    always_comb begin
        cnt_next  = cnt_reg;
        ivl_next  = ivl_reg;
        per_next  = per_reg;
        seen_next = seen_reg;
        if (edge_det) begin
            if (cnt_reg != '1) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
            // The first edge of a window only arms the interval counter.
            if (seen_reg) begin
                per_next = ivl_reg;
            end
            ivl_next  = PER_W'(1);
            seen_next = 1'b1;
        end else if (seen_reg && (ivl_reg != '1)) begin
            ivl_next = ivl_reg + PER_W'(1);
        end
    end

    // Values including an edge that lands on the terminal cycle.
    assign count_final  = cnt_next;
    assign period_final = per_next;

    // Idle and every window boundary wipe the history so intervals never span windows.
    always_ff @(posedge sysclk) begin
        if (!rst_n || !active || win_last) begin
            cnt_reg  <= '0;
            ivl_reg  <= '0;
            per_reg  <= '0;
            seen_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            ivl_reg  <= ivl_next;
            per_reg  <= per_next;
            seen_reg <= seen_next;
        end
    end

endmodule

// File: rtl/pulse_capture.sv
// Measures X/Y pulse trains over back-to-back fixed windows and hands each
// completed window's counts and periods to a valid/ready consumer.
module pulse_capture
    import pulse_capture_pkg::*;
#(
    parameter int WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W,
    parameter int PER_W         = DEFAULT_PER_W
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pulse_x,
    input  logic             pulse_y,
    output logic [CNT_W-1:0] count_x,
    output logic [CNT_W-1:0] count_y,
    output logic [PER_W-1:0] period_x,
    output logic [PER_W-1:0] period_y,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overrun
);

    localparam int               WIN_W    = win_cnt_width(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    cap_state_t       state_reg, state_next;
    logic [WIN_W-1:0] win_cnt_reg, win_cnt_next;
    logic             window_done;
    logic             active;
    logic             result_valid_reg;
    logic             overrun_reg;

    logic [1:0]       pulse_vec;
    logic [CNT_W-1:0] cnt_final   [2];
    logic [PER_W-1:0] per_final   [2];
    logic [CNT_W-1:0] res_cnt_reg [2];
    logic [PER_W-1:0] res_per_reg [2];

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            win_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            win_cnt_reg <= win_cnt_next;
        end
    end

    // Dropping enable wins over a terminal cycle: that window is discarded.
    always_comb begin
        state_next   = state_reg;
        win_cnt_next = win_cnt_reg;
        window_done  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                win_cnt_next = '0;
                if (enable) begin
                    state_next = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!enable) begin
                    state_next   = ST_IDLE;
                    win_cnt_next = '0;
                end else if (win_cnt_reg == WIN_LAST) begin
                    window_done  = 1'b1;
                    win_cnt_next = '0;
                end else begin
                    win_cnt_next = win_cnt_reg + WIN_W'(1);
                end
            end
        endcase
    end

    assign active    = (state_reg == ST_COUNT) && enable;
    assign pulse_vec = {pulse_y, pulse_x};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            pulse_capture_chan #(
                .CNT_W (CNT_W),
                .PER_W (PER_W)
            ) u_chan (
                .sysclk       (sysclk),
                .rst_n        (rst_n),
                .pulse        (pulse_vec[gi]),
                .active       (active),
                .win_last     (window_done),
                .count_final  (cnt_final[gi]),
                .period_final (per_final[gi])
            );

            always_ff @(posedge sysclk) begin
                if (!rst_n) begin
                    res_cnt_reg[gi] <= '0;
                    res_per_reg[gi] <= '0;
                end else if (window_done) begin
                    res_cnt_reg[gi] <= cnt_final[gi];
                    res_per_reg[gi] <= per_final[gi];
                end
            end
        end
    endgenerate

    // A load beats a coincident handshake; overrun only when the old result was never taken.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            result_valid_reg <= 1'b0;
            overrun_reg      <= 1'b0;
        end else if (window_done) begin
            result_valid_reg <= 1'b1;
            if (result_valid_reg && !result_ready) begin
                overrun_reg <= 1'b1;
            end
        end else if (result_valid_reg && result_ready) begin
            result_valid_reg <= 1'b0;
        end
    end

    assign count_x      = res_cnt_reg[0];
    assign count_y      = res_cnt_reg[1];
    assign period_x     = res_per_reg[0];
    assign period_y     = res_per_reg[1];
    assign result_valid = result_valid_reg;
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_pulse_capture.sv
// Directed bench for pulse_capture with a 100-cycle window and 4-bit counts;
// a pulse raised at a negedge in window cycle i produces an edge in cycle i+2.
module tb_pulse_capture;

    localparam int WIN = 100;
    localparam int CW  = 4;
    localparam int PW  = 8;

    logic          sysclk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          pulse_x;
    logic          pulse_y;
    logic          result_ready;
    logic [CW-1:0] count_x, count_y;
    logic [PW-1:0] period_x, period_y;
    logic          result_valid;
    logic          overrun;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 sysclk = ~sysclk;

    pulse_capture #(
        .WINDOW_CYCLES (WIN),
        .CNT_W         (CW),
        .PER_W         (PW)
    ) dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .enable       (enable),
        .pulse_x      (pulse_x),
        .pulse_y      (pulse_y),
        .count_x      (count_x),
        .count_y      (count_y),
        .period_x     (period_x),
        .period_y     (period_y),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overrun      (overrun)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_enable();
        @(negedge sysclk);
        enable = 1'b1;
        pulse_x = 1'b0;
        pulse_y = 1'b0;
        result_ready = 1'b0;
    endtask

    task automatic run_cycles(input int n, input int px, input int ox,
                              input int py, input int oy, input int rdy_at);
        for (int i = 0; i < n; i++) begin
            @(negedge sysclk);
            pulse_x = (px > 0) && (i >= ox) && (((i - ox) % px) == 0);
            pulse_y = (py > 0) && (i >= oy) && (((i - oy) % py) == 0);
            result_ready = (i == rdy_at);
        end
    endtask

    task automatic stop_enable();
        @(negedge sysclk);
        enable = 1'b0;
        result_ready = 1'b0;
        pulse_x = 1'b0;
        pulse_y = 1'b0;
        repeat (5) @(negedge sysclk);
    endtask

    task automatic consume(input string tag);
        @(negedge sysclk);
        result_ready = 1'b1;
        @(negedge sysclk);
        result_ready = 1'b0;
        n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL %s.consume_valid got %b want 0", tag, result_valid); end
    endtask

    task automatic show(input string tag);
        $display("[%0t] %s: valid=%b cx=%0d px=%0d cy=%0d py=%0d ovr=%b",
                 $time, tag, result_valid, count_x, period_x, count_y, period_y, overrun);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; pulse_x = 1'b0; pulse_y = 1'b0; result_ready = 1'b0;
        repeat (4) @(negedge sysclk);
        show("reset");
        n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL reset.valid got %b want 0", result_valid); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset.overrun got %b want 0", overrun); end
        n_cmp++; if (count_x !== 4'd0 || count_y !== 4'd0) begin n_bad++; $display("FAIL reset.counts got %0d/%0d want 0/0", count_x, count_y); end
        n_cmp++; if (period_x !== 8'd0 || period_y !== 8'd0) begin n_bad++; $display("FAIL reset.periods got %0d/%0d want 0/0", period_x, period_y); end
        rst_n = 1'b1;
        repeat (2) @(negedge sysclk);
    endtask

    task automatic test_basic();
        start_enable();
        run_cycles(WIN, 10, 0, 0, 0, -1);
        n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL basic.early_valid got %b want 0", result_valid); end
        @(posedge sysclk); #1;
        show("basic");
        n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL basic.valid got %b want 1", result_valid); end
        n_cmp++; if (count_x !== 4'd10) begin n_bad++; $display("FAIL basic.count_x got %0d want 10", count_x); end
        n_cmp++; if (period_x !== 8'd10) begin n_bad++; $display("FAIL basic.period_x got %0d want 10", period_x); end
        n_cmp++; if (count_y !== 4'd0) begin n_bad++; $display("FAIL basic.count_y got %0d want 0", count_y); end
        n_cmp++; if (period_y !== 8'd0) begin n_bad++; $display("FAIL basic.period_y got %0d want 0", period_y); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL basic.overrun got %b want 0", overrun); end
        stop_enable();
        consume("basic");
    endtask

    task automatic test_both_channels();
        start_enable();
        run_cycles(WIN, 25, 0, 7, 2, -1);
        @(posedge sysclk); #1;
        show("both");
        n_cmp++; if (count_x !== 4'd4) begin n_bad++; $display("FAIL both.count_x got %0d want 4", count_x); end
        n_cmp++; if (period_x !== 8'd25) begin n_bad++; $display("FAIL both.period_x got %0d want 25", period_x); end
        n_cmp++; if (count_y !== 4'd14) begin n_bad++; $display("FAIL both.count_y got %0d want 14", count_y); end
        n_cmp++; if (period_y !== 8'd7) begin n_bad++; $display("FAIL both.period_y got %0d want 7", period_y); end
        stop_enable();
        consume("both");
    endtask

    task automatic test_terminal_edge();
        start_enable();
        run_cycles(WIN, 1000, 97, 0, 0, -1);
        @(posedge sysclk); #1;
        show("terminal.w1");
        n_cmp++; if (count_x !== 4'd1) begin n_bad++; $display("FAIL terminal.count_x_w1 got %0d want 1", count_x); end
        n_cmp++; if (period_x !== 8'd0) begin n_bad++; $display("FAIL terminal.period_x_w1 got %0d want 0", period_x); end
        run_cycles(WIN, 0, 0, 0, 0, 5);
        @(posedge sysclk); #1;
        show("terminal.w2");
        n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL terminal.valid_w2 got %b want 1", result_valid); end
        n_cmp++; if (count_x !== 4'd0) begin n_bad++; $display("FAIL terminal.count_x_w2 got %0d want 0", count_x); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL terminal.overrun got %b want 0", overrun); end
        stop_enable();
        consume("terminal");
    endtask

    task automatic test_back_to_back_handshake();
        start_enable();
        run_cycles(WIN, 10, 0, 0, 0, -1);
        @(posedge sysclk); #1;
        show("coincide.w1");
        n_cmp++; if (count_x !== 4'd10) begin n_bad++; $display("FAIL coincide.count_x_w1 got %0d want 10", count_x); end
        run_cycles(WIN, 20, 0, 0, 0, WIN - 1);
        @(posedge sysclk); #1;
        show("coincide.w2");
        n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL coincide.valid got %b want 1", result_valid); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL coincide.overrun got %b want 0", overrun); end
        n_cmp++; if (count_x !== 4'd5) begin n_bad++; $display("FAIL coincide.count_x got %0d want 5", count_x); end
        n_cmp++; if (period_x !== 8'd20) begin n_bad++; $display("FAIL coincide.period_x got %0d want 20", period_x); end
        stop_enable();
        consume("coincide");
    endtask

    task automatic test_abort();
        start_enable();
        run_cycles(50, 10, 0, 0, 0, -1);
        @(negedge sysclk);
        enable = 1'b0;
        pulse_x = 1'b0;
        repeat (120) @(negedge sysclk);
        show("abort");
        n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL abort.valid got %b want 0", result_valid); end
        n_cmp++; if (count_x !== 4'd5) begin n_bad++; $display("FAIL abort.retained_count_x got %0d want 5", count_x); end
        start_enable();
        run_cycles(WIN, 10, 5, 33, 1, -1);
        n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL abort.early_valid got %b want 0", result_valid); end
        @(posedge sysclk); #1;
        show("abort.reenable");
        n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL abort.valid_full got %b want 1", result_valid); end
        n_cmp++; if (count_x !== 4'd10) begin n_bad++; $display("FAIL abort.count_x got %0d want 10", count_x); end
        n_cmp++; if (count_y !== 4'd3 || period_y !== 8'd33) begin n_bad++; $display("FAIL abort.y got %0d/%0d want 3/33", count_y, period_y); end
        stop_enable();
        consume("abort");
    endtask

    task automatic test_overrun();
        start_enable();
        run_cycles(WIN, 10, 0, 0, 0, -1);
        @(posedge sysclk); #1;
        show("overrun.w1");
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL overrun.w1 got %b want 0", overrun); end
        run_cycles(WIN, 25, 0, 0, 0, -1);
        @(posedge sysclk); #1;
        show("overrun.w2");
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun.flag got %b want 1", overrun); end
        n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL overrun.valid got %b want 1", result_valid); end
        n_cmp++; if (count_x !== 4'd4 || period_x !== 8'd25) begin n_bad++; $display("FAIL overrun.values got %0d/%0d want 4/25", count_x, period_x); end
        stop_enable();
        consume("overrun");
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun.sticky got %b want 1", overrun); end
    endtask

    task automatic test_reset_mid_window();
        start_enable();
        run_cycles(40, 2, 0, 0, 0, -1);
        @(negedge sysclk);
        rst_n = 1'b0; enable = 1'b0; pulse_x = 1'b0;
        repeat (3) @(negedge sysclk);
        show("midreset");
        n_cmp++; if (count_x !== 4'd0 || period_x !== 8'd0) begin n_bad++; $display("FAIL midreset.x got %0d/%0d want 0/0", count_x, period_x); end
        n_cmp++; if (result_valid !== 1'b0 || overrun !== 1'b0) begin n_bad++; $display("FAIL midreset.flags got %b/%b want 0/0", result_valid, overrun); end
        rst_n = 1'b1;
        repeat (2) @(negedge sysclk);
        start_enable();
        run_cycles(WIN, 5, 0, 0, 0, -1);
        @(posedge sysclk); #1;
        show("midreset.fresh");
        n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL midreset.valid got %b want 1", result_valid); end
        n_cmp++; if (count_x !== 4'd15) begin n_bad++; $display("FAIL midreset.sat_count got %0d want 15", count_x); end
        n_cmp++; if (period_x !== 8'd5) begin n_bad++; $display("FAIL midreset.period_x got %0d want 5", period_x); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL midreset.overrun got %b want 0", overrun); end
        stop_enable();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_both_channels();
        test_terminal_edge();
        test_back_to_back_handshake();
        test_abort();
        test_overrun();
        test_reset_mid_window();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
